// File: rtl/vrf_store_unit_pkg.sv
// Shared definitions for the vector store unit: default widths and the
// FSM state encoding. The VRF-facing widths match the VRF definitions.
package vrf_store_unit_pkg;

    localparam int VSU_DATA_W = 8;                        // lane / memory width
    localparam int VSU_LANES  = 4;                        // lanes per vector register
    localparam int VSU_ADDR_W = 8;                        // memory address width
    localparam int VSU_VREG_W = 2;                        // VRF register index width
    localparam int VSU_VEC_W  = VSU_DATA_W * VSU_LANES;   // VRF read data width

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LATCH = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/vrf_store_unit_if.sv
// Bundle of the command, VRF read-port and memory write-port signals of the
// vector store unit. The slave modport is the store unit's view.
interface vrf_store_unit_if
    import vrf_store_unit_pkg::*;
#(
    parameter int DATA_W = VSU_DATA_W,
    parameter int LANES  = VSU_LANES,
    parameter int ADDR_W = VSU_ADDR_W
);

    // Command side
    logic                      start;
    logic [VSU_VREG_W-1:0]     vreg;
    logic [ADDR_W-1:0]         base_addr;
    logic                      busy;
    logic                      done;

    // VRF read port
    logic [VSU_VREG_W-1:0]     vreg1;
    logic [DATA_W*LANES-1:0]   vdata1;

    // Memory write port
    logic [ADDR_W-1:0]         mem_addr;
    logic [DATA_W-1:0]         mem_dataw;
    logic                      MemWrite;
    logic                      mem_ready;

    modport slave (
        input  start, vreg, base_addr, vdata1, mem_ready,
        output vreg1, mem_addr, mem_dataw, MemWrite, busy, done
    );

    modport master (
        output start, vreg, base_addr, vdata1, mem_ready,
        input  vreg1, mem_addr, mem_dataw, MemWrite, busy, done
    );

endinterface

// File: rtl/vrf_store_unit_lane_mux.sv
// Combinational lane selector: picks byte lane `lane_i` out of the latched
// vector word, lane 0 being the least significant byte.
module vsu_lane_mux
    import vrf_store_unit_pkg::*;
#(
    parameter int DATA_W = VSU_DATA_W,
    parameter int LANES  = VSU_LANES,
    parameter int LANE_W = $clog2(LANES)
) (
    input  logic [DATA_W*LANES-1:0] buf_i,
    input  logic [LANE_W-1:0]       lane_i,
    output logic [DATA_W-1:0]       data_o
);

    // Select the addressed lane of the buffer
    always_comb begin
        data_o = '0;
        for (int i = 0; i < LANES; i++) begin
            if (lane_i == LANE_W'(i)) begin
                data_o = buf_i[i*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/vrf_store_unit.sv
// Vector store engine: on a start command it snapshots one VRF register and
// writes its lanes, lane 0 first, to consecutive byte addresses through a
// write/ready handshake. Outputs depend only on registered state, so there
// is no combinational path from mem_ready to any output.
module vrf_store_unit
    import vrf_store_unit_pkg::*;
#(
    parameter int DATA_W = VSU_DATA_W,
    parameter int LANES  = VSU_LANES,
    parameter int ADDR_W = VSU_ADDR_W
) (
    input  logic             clock,
    input  logic             reset,
    vrf_store_unit_if.slave  bus
);

    localparam int                LANE_W    = $clog2(LANES);
    localparam int                VEC_W     = DATA_W * LANES;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

    state_e                  state_q, state_d;
    logic [LANE_W-1:0]       lane_q,  lane_d;
    logic [VSU_VREG_W-1:0]   vreg_q,  vreg_d;
    logic [ADDR_W-1:0]       addr_q,  addr_d;
    logic [VEC_W-1:0]        buf_q,   buf_d;
    logic [DATA_W-1:0]       lane_data;

    // State, lane counter, command and data registers; reset clears all of them
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            lane_q  <= '0;
            vreg_q  <= '0;
            addr_q  <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            vreg_q  <= vreg_d;
            addr_q  <= addr_d;
            buf_q   <= buf_d;
        end
    end

    // Next-state logic: accept a command in IDLE, snapshot the VRF word in
    // LATCH, step through the lanes on each accepted write in WRITE
    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        vreg_d  = vreg_q;
        addr_d  = addr_q;
        buf_d   = buf_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    vreg_d  = bus.vreg;
                    addr_d  = bus.base_addr;
                    lane_d  = '0;
                    state_d = ST_LATCH;
                end
            end
            ST_LATCH: begin
                // vreg1 has been stable for the whole cycle, so the
                // combinational VRF read is valid at this edge
                buf_d   = bus.vdata1;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                if (bus.mem_ready) begin
                    if (lane_q == LAST_LANE) begin
                        state_d = ST_DONE;
                    end else begin
                        lane_d = lane_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    vsu_lane_mux #(
        .DATA_W (DATA_W),
        .LANES  (LANES),
        .LANE_W (LANE_W)
    ) u_lane_mux (
        .buf_i  (buf_q),
        .lane_i (lane_q),
        .data_o (lane_data)
    );

    // Address and data are driven only while a write is requested; the
    // address sum wraps naturally at the ADDR_W boundary
    assign bus.MemWrite  = (state_q == ST_WRITE);
    assign bus.mem_addr  = bus.MemWrite ? (addr_q + ADDR_W'(lane_q)) : '0;
    assign bus.mem_dataw = bus.MemWrite ? lane_data : '0;
    assign bus.vreg1     = vreg_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = (state_q == ST_DONE);

endmodule
